// File: rtl/program_loader.sv
// Boot loader: turns a counted, checksummed byte stream into 16-bit RAM words and releases the CPU.
// Latency: one accepted byte per cycle; each word costs a write cycle after its low byte.
// Backpressure: ByteReady is decoded from state only and drops during the write cycle and once terminal.
module program_loader #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  output logic [ADDR_W-1:0] RamAddrB,
  output logic [15:0]       RamDataB,
  output logic              RamWeB,
  output logic              CpuRun,
  output logic              LoadErr
);

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q;
  logic [7:0]          cnt_hi_q;
  logic [ADDR_W:0]     cnt_q;      // one extra bit so a full 2**ADDR_W image fits
  logic [ADDR_W:0]     idx_q;
  logic [7:0]          hi_q;
  logic [7:0]          acc_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         data_q;
  logic                we_q;
  logic                run_q;
  logic                err_q;

  logic                accept_d;
  logic [15:0]         cnt_full_d;
  logic [ADDR_W:0]     idx_inc_d;
  logic                too_big_d;

  // Ready depends only on the current state, never on ByteValid.
  always_comb begin
    ByteReady = 1'b0;
    case (state_q)
      S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO, S_CHK: ByteReady = 1'b1;
      default:                                       ByteReady = 1'b0;
    endcase
  end

  assign accept_d   = ByteValid && ByteReady;
  assign cnt_full_d = {cnt_hi_q, ByteIn};
  assign idx_inc_d  = idx_q + 1'b1;
  assign too_big_d  = ({16'd0, cnt_full_d} > MAX_WORDS);

  // Loader FSM; all outputs are registered here so CpuRun/LoadErr/RamWeB cannot glitch.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_CNT_HI;
      cnt_hi_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      hi_q     <= '0;
      acc_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_CNT_HI: begin
          if (accept_d) begin
            cnt_hi_q <= ByteIn;
            state_q  <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (accept_d) begin
            cnt_q <= cnt_full_d[ADDR_W:0];
            if (too_big_d) begin
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end else if (cnt_full_d == 16'd0) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_DAT_HI;
            end
          end
        end
        S_DAT_HI: begin
          if (accept_d) begin
            hi_q    <= ByteIn;
            acc_q   <= acc_q ^ ByteIn;
            state_q <= S_DAT_LO;
          end
        end
        S_DAT_LO: begin
          if (accept_d) begin
            acc_q   <= acc_q ^ ByteIn;
            data_q  <= {hi_q, ByteIn};
            addr_q  <= idx_q[ADDR_W-1:0];
            we_q    <= 1'b1;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          // The write strobe is high for exactly this one cycle.
          idx_q   <= idx_inc_d;
          state_q <= (idx_inc_d == cnt_q) ? S_CHK : S_DAT_HI;
        end
        S_CHK: begin
          if (accept_d) begin
            if (ByteIn == acc_q) begin
              run_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end
          end
        end
        S_DONE:  state_q <= S_DONE;
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_ERR;
      endcase
    end
  end

  assign RamAddrB = addr_q;
  assign RamDataB = data_q;
  assign RamWeB   = we_q;
  assign CpuRun   = run_q;
  assign LoadErr  = err_q;

endmodule
